vga_vu_display: RTL and testbench
=================================

VGA_VU_DISPLAY -- requirements
Module: vga_vu_display

Interface
REQ-001 Parameter THADDR, 640, horizontal addressable pixels.
REQ-002 Parameters THFP/THS/THBP/THBD, 16/96/48/0, horizontal front porch/sync/back porch/border widths, in pixels.
REQ-003 Parameters TVADDR/TVFP/TVS/TVBP/TVBD, 480/10/2/33/0, the same vertical quantities, in lines.
REQ-004 Parameters H_POL/V_POL, 0/0: 0 means the sync pulse is active-low, 1 means active-high.
REQ-005 Parameter N_CH, 2, number of meter channels (1..8).
REQ-006 Parameter LVL_W, 8, width of each level sample.
REQ-007 Parameter PEAK_HOLD, 30, number of frames the peak is held before it starts to decay.
REQ-008 pixel_clock  in  1  sole clock; all logic is rising-edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 level  in  N_CH*LVL_W  unsigned channel levels; channel i occupies bits [i*LVL_W +: LVL_W].
REQ-011 level_valid  in  1  while high, level is captured into the shadow registers at that edge.
REQ-012 h_sync, v_sync  out  1 each  sync outputs, registered.
REQ-013 red/green/blue  out  3/3/2  pixel colour, registered.
REQ-014 frame_start  out  1  one-cycle pulse aligned with output pixel (0,0).

Function
REQ-015 HTOTAL = THADDR+2*THBD+THFP+THS+THBP; h counts 0..HTOTAL-1 and wraps to 0; v increments at the h wrap, counts 0..VTOTAL-1 and wraps (VTOTAL is defined the same way).
REQ-016 Horizontal order from h=0: addressable, right border, front porch, sync, back porch, left border; vertical order is identical (addressable, bottom border, FP, sync, BP, top border).
REQ-017 Sync active while h is in [THADDR+THBD+THFP, THADDR+THBD+THFP+THS) (vertical analogous); active level per H_POL/V_POL, inverse level otherwise.
REQ-018 Every output has exactly 1 cycle of latency from the counters; sync, colour and frame_start stay mutually aligned.
REQ-019 Blanking (h or v inside FP/sync/BP) outputs colour 0.
REQ-020 Border pixel (non-blanking, border in either dimension) outputs blue=3, red=green=0.
REQ-021 Display update: on the edge where h=HTOTAL-1 and v=VTOTAL-1, each channel's displayed level is loaded from its shadow register.
REQ-022 If level_valid is high on that same edge, the display loads the pre-edge shadow value, and the new sample appears one frame later.
REQ-023 Fill threshold thr_i = (level_i*THADDR)>>LVL_W, computed at update with LVL_W+clog2(THADDR) bits and no truncation before the shift; peak column pk_i is the same formula applied to peak_i.
REQ-024 Peak update per channel at display update: if level >= peak, then peak=level and hold=PEAK_HOLD; else if hold>0, then hold decrements; else peak decrements by 1 (saturating at 0).
REQ-025 Channel band i covers addressable rows [i*B, (i+1)*B) with B=TVADDR/N_CH (integer division); leftover rows output black.
REQ-026 Within band i at column x: if x==pk_i, output white (7,7,3); else if x<thr_i, output the zone colour; else output black.
REQ-027 Zone colour: green (0,7,0) for x<(5*THADDR)/8; yellow (7,7,0) for x<(7*THADDR)/8; red (7,0,0) otherwise.

Reset
REQ-028 While reset is low: h=v=0, all shadow, display, peak and hold registers are 0, colour outputs are 0, frame_start=0, and h_sync/v_sync sit at their inactive levels.
REQ-029 Reset takes effect asynchronously mid-frame; after release, counting restarts at (0,0) and the first frame_start occurs 1 cycle after the first rising edge.

Verification
REQ-030 Timing: THADDR=4,THFP=1,THS=3,THBP=2,THBD=0 with vertical identical -> h_sync low 3 of every 10 cycles; v_sync low 30 of every 100; frame_start every 100 cycles.
REQ-031 Fill: THADDR=8,LVL_W=3,N_CH=1, level=4 pulsed valid -> from the next frame, x0..3 green, x4 white, x5..7 black on every addressable row.
REQ-032 Zones: same setup, level=7 -> x0..4 green, x5..6 yellow, x7 white.
REQ-033 Peak: PEAK_HOLD=2, level 6 then held at 2 -> peak is 6 for 3 updates, then 5,4,3,2, then re-armed at 2 with hold=2.
REQ-034 Mid-frame reset at h=3,v=2 -> colours immediately 0 and syncs inactive; after release, timing matches REQ-030 from (0,0) with levels cleared.
REQ-035 H_POL=V_POL=1, THBD=TVBD=1 -> syncs idle 0 and pulse 1; border columns/rows show blue=3.

Source files
------------

// File: rtl/vga_vu_display.sv
// VGA timing generator with an N-channel horizontal bar VU meter and per-channel peak markers.
// Colour, sync and frame_start are registered one cycle after the h/v counters.
module vga_vu_display #(
    parameter int THADDR    = 640,
    parameter int THFP      = 16,
    parameter int THS       = 96,
    parameter int THBP      = 48,
    parameter int THBD      = 0,
    parameter int TVADDR    = 480,
    parameter int TVFP      = 10,
    parameter int TVS       = 2,
    parameter int TVBP      = 33,
    parameter int TVBD      = 0,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int N_CH      = 2,
    parameter int LVL_W     = 8,
    parameter int PEAK_HOLD = 30
) (
    input  logic                    pixel_clock,
    input  logic                    reset,
    input  logic [N_CH*LVL_W-1:0]   level,
    input  logic                    level_valid,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic [2:0]              red,
    output logic [2:0]              green,
    output logic [1:0]              blue,
    output logic                    frame_start
);

    localparam int HTOTAL = THADDR + 2*THBD + THFP + THS + THBP;
    localparam int VTOTAL = TVADDR + 2*TVBD + TVFP + TVS + TVBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int PW     = LVL_W + $clog2(THADDR);
    localparam int HDW    = $clog2(PEAK_HOLD + 2);
    localparam int BAND   = TVADDR / N_CH;

    localparam logic [HW-1:0]  H_LAST   = HW'(HTOTAL - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(VTOTAL - 1);
    localparam logic [HW-1:0]  H_ADDR   = HW'(THADDR);
    localparam logic [VW-1:0]  V_ADDR   = VW'(TVADDR);
    localparam logic [HW-1:0]  HB_FIRST = HW'(THADDR + THBD);
    localparam logic [HW-1:0]  HB_LAST  = HW'(HTOTAL - THBD - 1);
    localparam logic [VW-1:0]  VB_FIRST = VW'(TVADDR + TVBD);
    localparam logic [VW-1:0]  VB_LAST  = VW'(VTOTAL - TVBD - 1);
    localparam logic [HW-1:0]  HS_FIRST = HW'(THADDR + THBD + THFP);
    localparam logic [HW-1:0]  HS_LAST  = HW'(THADDR + THBD + THFP + THS - 1);
    localparam logic [VW-1:0]  VS_FIRST = VW'(TVADDR + TVBD + TVFP);
    localparam logic [VW-1:0]  VS_LAST  = VW'(TVADDR + TVBD + TVFP + TVS - 1);
    localparam logic [HW-1:0]  Z_GREEN  = HW'((5*THADDR)/8);
    localparam logic [HW-1:0]  Z_YELLOW = HW'((7*THADDR)/8);
    localparam logic [HDW-1:0] HOLD_INIT = HDW'(PEAK_HOLD);

    logic [HW-1:0]    r_h;
    logic [VW-1:0]    r_v;
    logic [LVL_W-1:0] r_shadow [N_CH];
    logic [LVL_W-1:0] r_peak   [N_CH];
    logic [HDW-1:0]   r_hold   [N_CH];
    logic [HW-1:0]    r_thr    [N_CH];
    logic [HW-1:0]    r_pk     [N_CH];

    logic [LVL_W-1:0] w_peak_nxt [N_CH];
    logic [HDW-1:0]   w_hold_nxt [N_CH];
    logic             w_h_last, w_v_last, w_frame_end;
    logic             w_blank, w_border, w_in_band;
    logic [HW-1:0]    w_thr_sel, w_pk_sel;
    logic [2:0]       w_r, w_g;
    logic [1:0]       w_b;

    // Column index for a level: full-width product so the shift never loses bits.
    function automatic logic [HW-1:0] col_of(input logic [LVL_W-1:0] lv);
        logic [PW-1:0] prod;
        prod = PW'(lv) * PW'(THADDR);
        return HW'(prod >> LVL_W);
    endfunction

    assign w_h_last    = (r_h == H_LAST);
    assign w_v_last    = (r_v == V_LAST);
    assign w_frame_end = w_h_last && w_v_last;

    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_peak_nxt[i] = r_peak[i];
            w_hold_nxt[i] = r_hold[i];
            if (r_shadow[i] >= r_peak[i]) begin
                w_peak_nxt[i] = r_shadow[i];
                w_hold_nxt[i] = HOLD_INIT;
            end else if (r_hold[i] != '0) begin
                w_hold_nxt[i] = r_hold[i] - 1'b1;
            end else if (r_peak[i] != '0) begin
                w_peak_nxt[i] = r_peak[i] - 1'b1;
            end
        end
    end

    // Shadow capture and once-per-frame display/peak update; the update reads the pre-edge shadow.
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_shadow[i] <= '0;
                r_peak[i]   <= '0;
                r_hold[i]   <= '0;
                r_thr[i]    <= '0;
                r_pk[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (level_valid)
                    r_shadow[i] <= level[i*LVL_W +: LVL_W];
                if (w_frame_end) begin
                    r_thr[i]  <= col_of(r_shadow[i]);
                    r_peak[i] <= w_peak_nxt[i];
                    r_hold[i] <= w_hold_nxt[i];
                    r_pk[i]   <= col_of(w_peak_nxt[i]);
                end
            end
        end
    end

    assign w_blank  = (r_h >= HB_FIRST && r_h <= HB_LAST) || (r_v >= VB_FIRST && r_v <= VB_LAST);
    assign w_border = (r_h >= H_ADDR) || (r_v >= V_ADDR);

    always_comb begin
        w_r       = '0;
        w_g       = '0;
        w_b       = '0;
        w_in_band = 1'b0;
        w_thr_sel = '0;
        w_pk_sel  = '0;
        // Descending scan: the last hit is the lowest band whose upper bound lies above r_v.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_v < VW'((i + 1) * BAND)) begin
                w_in_band = 1'b1;
                w_thr_sel = r_thr[i];
                w_pk_sel  = r_pk[i];
            end
        end
        if (!w_blank) begin
            if (w_border) begin
                w_b = 2'd3;
            end else if (w_in_band) begin
                if (r_h == w_pk_sel) begin
                    w_r = 3'd7;
                    w_g = 3'd7;
                    w_b = 2'd3;
                end else if (r_h < w_thr_sel) begin
                    if (r_h < Z_GREEN) begin
                        w_g = 3'd7;
                    end else if (r_h < Z_YELLOW) begin
                        w_r = 3'd7;
                        w_g = 3'd7;
                    end else begin
                        w_r = 3'd7;
                    end
                end
            end
        end
    end

    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            h_sync      <= ~H_POL;
            v_sync      <= ~V_POL;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= (r_h >= HS_FIRST && r_h <= HS_LAST) ? H_POL : ~H_POL;
            v_sync      <= (r_v >= VS_FIRST && r_v <= VS_LAST) ? V_POL : ~V_POL;
            red         <= w_r;
            green       <= w_g;
            blue        <= w_b;
            frame_start <= (r_h == '0) && (r_v == '0);
        end
    end

endmodule

// File: tb/tb_vga_vu_display.sv
// Randomized bench for vga_vu_display: every output cycle is compared with a frame-level
// reference model built from raster position arithmetic and the meter rules.
module tb_vga_vu_display;

    localparam int THADDR = 16, THFP = 1, THS = 3, THBP = 2, THBD = 1;
    localparam int TVADDR = 7,  TVFP = 1, TVS = 2, TVBP = 1, TVBD = 1;
    localparam bit H_POL = 1'b1, V_POL = 1'b0;
    localparam int N_CH = 2, LVL_W = 4, PEAK_HOLD = 2;
    localparam int HT = THADDR + 2*THBD + THFP + THS + THBP;
    localparam int VT = TVADDR + 2*TVBD + TVFP + TVS + TVBP;
    localparam int FRAME = HT * VT;
    localparam int B = TVADDR / N_CH;
    localparam logic [10:0] RST_WORD = {~H_POL, ~V_POL, 9'd0};

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N_CH*LVL_W-1:0] lvl = '0;
    logic                  vld = 1'b0;
    logic                  hs, vs, fs;
    logic [2:0]            r, g;
    logic [1:0]            b;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    int m_t;
    int m_shadow [N_CH];
    int m_thr    [N_CH];
    int m_pk     [N_CH];
    int m_peak   [N_CH];
    int m_hold   [N_CH];

    vga_vu_display #(
        .THADDR(THADDR), .THFP(THFP), .THS(THS), .THBP(THBP), .THBD(THBD),
        .TVADDR(TVADDR), .TVFP(TVFP), .TVS(TVS), .TVBP(TVBP), .TVBD(TVBD),
        .H_POL(H_POL), .V_POL(V_POL), .N_CH(N_CH), .LVL_W(LVL_W), .PEAK_HOLD(PEAK_HOLD)
    ) dut (
        .pixel_clock(clk),
        .reset(rst_n),
        .level(lvl),
        .level_valid(vld),
        .h_sync(hs),
        .v_sync(vs),
        .red(r),
        .green(g),
        .blue(b),
        .frame_start(fs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got {hs,vs,r,g,b,fs}=%b_%b_%0d_%0d_%0d_%b expected %b_%b_%0d_%0d_%0d_%b at %0t",
                     tag, got[10], got[9], got[8:6], got[5:3], got[2:1], got[0],
                     exp[10], exp[9], exp[8:6], exp[5:3], exp[2:1], exp[0], $time);
        end
    endtask

    function automatic logic [10:0] dut_word();
        return {hs, vs, r, g, b, fs};
    endfunction

    function automatic logic [10:0] exp_word(input int h, input int v);
        logic       ehs, evs, blank;
        logic [2:0] er, eg;
        logic [1:0] eb;
        int         band;
        ehs = (h >= THADDR+THBD+THFP && h < THADDR+THBD+THFP+THS) ? H_POL : ~H_POL;
        evs = (v >= TVADDR+TVBD+TVFP && v < TVADDR+TVBD+TVFP+TVS) ? V_POL : ~V_POL;
        blank = (h >= THADDR+THBD && h < HT-THBD) || (v >= TVADDR+TVBD && v < VT-TVBD);
        er = 0; eg = 0; eb = 0;
        if (!blank) begin
            if (h >= THADDR || v >= TVADDR) begin
                eb = 3;
            end else begin
                band = v / B;
                if (band < N_CH) begin
                    if (h == m_pk[band]) begin
                        er = 7; eg = 7; eb = 3;
                    end else if (h < m_thr[band]) begin
                        if (h < (5*THADDR)/8)      eg = 7;
                        else if (h < (7*THADDR)/8) begin er = 7; eg = 7; end
                        else                       er = 7;
                    end
                end
            end
        end
        return {ehs, evs, er, eg, eb, (h == 0 && v == 0)};
    endfunction

    task automatic model_reset();
        m_t = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_shadow[c] = 0; m_thr[c] = 0; m_pk[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
        end
    endtask

    task automatic frame_update();
        for (int c = 0; c < N_CH; c++) begin
            m_thr[c] = (m_shadow[c] * THADDR) >> LVL_W;
            if (m_shadow[c] >= m_peak[c]) begin
                m_peak[c] = m_shadow[c];
                m_hold[c] = PEAK_HOLD;
            end else if (m_hold[c] > 0) begin
                m_hold[c]--;
            end else if (m_peak[c] > 0) begin
                m_peak[c]--;
            end
            m_pk[c] = (m_peak[c] * THADDR) >> LVL_W;
        end
    endtask

    // One pixel clock: predict the output of this edge from pre-edge state, then check it.
    task automatic step(input string tag);
        int h, v;
        logic [10:0] e;
        @(posedge clk);
        h = m_t % HT;
        v = (m_t / HT) % VT;
        e = exp_word(h, v);
        if (h == HT-1 && v == VT-1) frame_update();
        if (vld)
            for (int c = 0; c < N_CH; c++) m_shadow[c] = int'(lvl[c*LVL_W +: LVL_W]);
        m_t++;
        @(negedge clk);
        chk(tag, dut_word(), e);
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_hold", dut_word(), RST_WORD);
        @(negedge clk);
        chk("reset_hold2", dut_word(), RST_WORD);
        rst_n = 1'b1;

        lvl = {4'd15, 4'd4};
        vld = 1'b1;
        step("fill_load");
        vld = 1'b0;
        run(2*FRAME, "fill");

        lvl = {4'd9, 4'd6};
        vld = 1'b1;
        step("peak_load");
        vld = 1'b0;
        run(FRAME, "peak_high");
        lvl = {4'd0, 4'd2};
        vld = 1'b1;
        run(9*FRAME, "peak_decay");
        vld = 1'b0;

        for (int k = 0; k < FRAME && !((m_t % HT) == 3 && ((m_t / HT) % VT) == 2); k++)
            step("seek");
        if (!((m_t % HT) == 3 && ((m_t / HT) % VT) == 2))
            chk("seek_timeout", 11'd0, 11'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", dut_word(), RST_WORD);
        lvl = {4'd15, 4'd15};
        vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_mid", dut_word(), RST_WORD);
        end
        vld = 1'b0;
        model_reset();
        rst_n = 1'b1;
        run(3*FRAME, "after_reset");

        for (int k = 0; k < 18*FRAME; k++) begin
            vld = ($urandom_range(0, 59) == 0);
            lvl = N_CH*LVL_W'($urandom);
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
